// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer and the renderer: scene codes,
// objective codes, default frame constants, menu sizes and small helpers.
package game_flow_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8,
    ST_HELP     = 4'd9
  } game_state_e;

  typedef enum logic [1:0] {
    TODO_NONE       = 2'd0,
    TODO_FIND_KEY   = 2'd1,
    TODO_FIND_LIGHT = 2'd2,
    TODO_FIND_DOOR  = 2'd3
  } todo_e;

  localparam int DEF_TIME_LIMIT_FRAMES = 3600;
  localparam int DEF_INVULN_FRAMES     = 60;

  localparam logic [1:0] TITLE_ITEMS   = 2'd3;
  localparam logic [1:0] SUCCESS_ITEMS = 2'd2;
  localparam logic [1:0] FAIL_ITEMS    = 2'd2;
  localparam logic [1:0] SINGLE_ITEMS  = 2'd1;
  localparam logic [1:0] FULL_LIFE     = 2'd3;
  localparam logic [3:0] PLAY_VALID_RST = 4'b0010;

  // Number of selectable items shown in a given scene.
  function automatic logic [1:0] menu_items(input game_state_e st);
    case (st)
      ST_TITLE:    return TITLE_ITEMS;
      ST_SUCCESS1: return SUCCESS_ITEMS;
      ST_SUCCESS2: return SUCCESS_ITEMS;
      ST_FAIL:     return FAIL_ITEMS;
      default:     return SINGLE_ITEMS;
    endcase
  endfunction

  // Cursor move with wrap-around; opposing presses cancel out.
  function automatic logic [1:0] menu_step(input logic [1:0] sel, input logic [1:0] items,
                                           input logic up, input logic down);
    if (up && !down) begin
      return (sel == 2'd0) ? (items - 2'd1) : (sel - 2'd1);
    end else if (down && !up) begin
      return (sel == (items - 2'd1)) ? 2'd0 : (sel + 2'd1);
    end else begin
      return sel;
    end
  endfunction

  // Stage number (1..3) of a stage scene, 0 otherwise.
  function automatic logic [1:0] stage_num(input game_state_e st);
    case (st)
      ST_STAGE1: return 2'd1;
      ST_STAGE2: return 2'd2;
      ST_STAGE3: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic game_state_e stage_state(input logic [1:0] n);
    case (n)
      2'd1:    return ST_STAGE1;
      2'd2:    return ST_STAGE2;
      2'd3:    return ST_STAGE3;
      default: return ST_TITLE;
    endcase
  endfunction

  function automatic game_state_e success_state(input logic [1:0] n);
    case (n)
      2'd1:    return ST_SUCCESS1;
      2'd2:    return ST_SUCCESS2;
      2'd3:    return ST_SUCCESS3;
      default: return ST_TITLE;
    endcase
  endfunction

  // Stage 2 opens in the dark, so the light must be found first.
  function automatic todo_e first_todo(input logic [1:0] n);
    case (n)
      2'd2:    return TODO_FIND_LIGHT;
      default: return TODO_FIND_KEY;
    endcase
  endfunction

  // Unlock bit granted by clearing stage n.
  function automatic logic [3:0] unlock_mask(input logic [1:0] n);
    case (n)
      2'd1:    return 4'b0100;
      2'd2:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_down_counter.sv
// Frame-paced down counter: load wins over tick, decrements on tick and
// holds at zero. W must be at least 2.
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count_r;

  // Count register: reload on request, otherwise saturating decrement per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r != '0)) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);
  assign one  = (count_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/game_flow_ctrl.sv
// Game scene sequencer: menus, stage objectives, lives and stage unlocks.
// Optional stage timeout is compiled in when GAME_TIME_LIMIT_EN is defined.
module game_flow_ctrl
  import game_flow_ctrl_pkg::*;
#(
  parameter int TIME_LIMIT_FRAMES = DEF_TIME_LIMIT_FRAMES,
  parameter int INVULN_FRAMES     = DEF_INVULN_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_help,
  input  logic       key_hit,
  input  logic       light_hit,
  input  logic       door_hit,
  input  logic       trap_hit,
  output logic [3:0] state,
  output logic [1:0] todo,
  output logic [1:0] key_find,
  output logic [1:0] life,
  output logic [3:0] play_valid,
  output logic [1:0] menu_sel,
  output logic       stage_start
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  game_state_e state_r, state_n;
  todo_e       todo_r, todo_n;
  logic [1:0]  key_r, key_n;
  logic [1:0]  life_r, life_n;
  logic [3:0]  pv_r, pv_n;
  logic [1:0]  sel_r, sel_n;
  logic        start_r;
  logic [1:0]  last_r, last_n;

  logic             enter_s;
  logic [1:0]       enter_num_s;
  logic [1:0]       cur_stage_s;
  logic [1:0]       title_pick_s;
  logic             inv_load_s;
  logic [INV_W-1:0] inv_load_val_s;
  logic             inv_zero_s;
  logic             inv_one_unused_s;
  logic             timeout_s;

  frame_down_counter #(.W(INV_W)) u_invuln (
    .clk      (clk),
    .rst      (rst),
    .load     (inv_load_s),
    .load_val (inv_load_val_s),
    .tick     (frame_tick),
    .zero     (inv_zero_s),
    .one      (inv_one_unused_s)
  );

`ifdef GAME_TIME_LIMIT_EN
  localparam int TMR_W = $clog2(TIME_LIMIT_FRAMES + 1);
  logic tmr_zero_unused_s;
  logic tmr_one_s;

  frame_down_counter #(.W(TMR_W)) u_stage_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_s),
    .load_val (TMR_W'(TIME_LIMIT_FRAMES)),
    .tick     (frame_tick),
    .zero     (tmr_zero_unused_s),
    .one      (tmr_one_s)
  );

  // The frame that takes the timer from 1 to 0 is the timeout.
  assign timeout_s = frame_tick & tmr_one_s;
`else
  localparam int UNUSED_TIME_LIMIT = TIME_LIMIT_FRAMES;
  assign timeout_s = 1'b0;
`endif

  assign cur_stage_s  = stage_num(state_r);
  assign title_pick_s = sel_r + 2'd1;

  // Next-state, objective, lives, unlocks and counter loads.
  always_comb begin
    state_n        = state_r;
    todo_n         = todo_r;
    key_n          = key_r;
    life_n         = life_r;
    pv_n           = pv_r;
    last_n         = last_r;
    enter_s        = 1'b0;
    enter_num_s    = 2'd0;
    inv_load_s     = 1'b0;
    inv_load_val_s = '0;
    sel_n          = sel_r;

    case (state_r)
      ST_TITLE: begin
        if (btn_sel) begin
          if (pv_r[title_pick_s]) begin
            enter_s     = 1'b1;
            enter_num_s = title_pick_s;
          end else begin
            state_n = ST_TITLE;
          end
        end else if (btn_help) begin
          state_n = ST_HELP;
        end else begin
          state_n = ST_TITLE;
        end
      end
      ST_HELP, ST_STAFF: begin
        if (btn_sel) begin
          state_n = ST_TITLE;
        end else begin
          state_n = state_r;
        end
      end
      ST_SUCCESS1, ST_SUCCESS2: begin
        if (btn_sel && (sel_r == 2'd0)) begin
          enter_s     = 1'b1;
          enter_num_s = (state_r == ST_SUCCESS1) ? 2'd2 : 2'd3;
        end else if (btn_sel) begin
          state_n = ST_TITLE;
        end else begin
          state_n = state_r;
        end
      end
      ST_SUCCESS3: begin
        if (btn_sel) begin
          state_n = ST_STAFF;
        end else begin
          state_n = state_r;
        end
      end
      ST_FAIL: begin
        if (btn_sel && (sel_r == 2'd0)) begin
          enter_s     = 1'b1;
          enter_num_s = last_r;
        end else if (btn_sel) begin
          state_n = ST_TITLE;
        end else begin
          state_n = state_r;
        end
      end
      ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
        // One event per cycle, highest priority wins; the rest are dropped.
        if (door_hit && (todo_r == TODO_FIND_DOOR)) begin
          state_n = success_state(cur_stage_s);
          pv_n    = pv_r | unlock_mask(cur_stage_s);
          todo_n  = TODO_NONE;
        end else if ((state_r == ST_STAGE3) && trap_hit && inv_zero_s) begin
          inv_load_s     = 1'b1;
          inv_load_val_s = INV_W'(INVULN_FRAMES);
          life_n         = life_r - 2'd1;
          if (life_r == 2'd1) begin
            state_n = ST_FAIL;
          end else begin
            state_n = state_r;
          end
        end else if (timeout_s) begin
          state_n = ST_FAIL;
        end else if (light_hit && (todo_r == TODO_FIND_LIGHT)) begin
          todo_n = TODO_FIND_KEY;
        end else if (key_hit && (todo_r == TODO_FIND_KEY)) begin
          key_n = key_r + 2'd1;
          if (key_r == 2'd2) begin
            todo_n = TODO_FIND_DOOR;
          end else begin
            todo_n = todo_r;
          end
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_TITLE;
      end
    endcase

    if (enter_s) begin
      state_n        = stage_state(enter_num_s);
      todo_n         = first_todo(enter_num_s);
      key_n          = 2'd0;
      life_n         = FULL_LIFE;
      last_n         = enter_num_s;
      inv_load_s     = 1'b1;
      inv_load_val_s = '0;
    end else begin
      last_n = last_r;
    end

    // Cursor resets on any scene change; select already used the old value.
    if (state_n != state_r) begin
      sel_n = 2'd0;
    end else begin
      sel_n = menu_step(sel_r, menu_items(state_r), btn_up, btn_down);
    end
  end

  // Scene and HUD registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_TITLE;
      todo_r  <= TODO_NONE;
      key_r   <= 2'd0;
      life_r  <= FULL_LIFE;
      pv_r    <= PLAY_VALID_RST;
      sel_r   <= 2'd0;
      start_r <= 1'b0;
      last_r  <= 2'd1;
    end else begin
      state_r <= state_n;
      todo_r  <= todo_n;
      key_r   <= key_n;
      life_r  <= life_n;
      pv_r    <= pv_n;
      sel_r   <= sel_n;
      start_r <= enter_s;
      last_r  <= last_n;
    end
  end

  assign state       = state_r;
  assign todo        = todo_r;
  assign key_find    = key_r;
  assign life        = life_r;
  assign play_valid  = pv_r;
  assign menu_sel    = sel_r;
  assign stage_start = start_r;

endmodule
